mux_rr_scheduler: RTL and testbench
===================================

// Module: mux_rr_scheduler
// PURPOSE
//  Round-robin burst scheduler that shares the registered N-to-1 mux between
//  INPUT_COUNT requesters. It picks an owner, drives the mux sel, and issues a
//  per-beat grant to the owner, honouring downstream back-pressure. It emits
//  out_valid/out_src aligned with the mux's registered data_out, one cycle
//  after the grant. Sits beside the mux instance; requesters drive their own
//  data_in slice.
// PARAMETERS
//  INPUT_COUNT  8  number of requesters / mux inputs; legal range >= 2
//  BURST_MAX    4  max beats per grant before forced rotation; legal range >= 1
//  SEL_W        $clog2(INPUT_COUNT)  localparam; width of sel/owner
//  CNT_W        $clog2(BURST_MAX+1)  localparam; beat counter width
// PORTS
//  clk        in   1            clock; all state updates on posedge
//  rst_n      in   1            reset, synchronous, active-low
//  req        in   INPUT_COUNT  req[i]=1: requester i has a beat on its slice
//  last       in   INPUT_COUNT  last[i]=1: current beat of i ends its burst
//  dn_ready   in   1            downstream can accept a beat this cycle
//  gnt        out  INPUT_COUNT  one-hot beat accept; combinational from state
//  sel        out  SEL_W        mux select (registered, = owner)
//  busy       out  1            1 while in BUSY state
//  out_valid  out  1            mux data_out holds a valid beat this cycle
//  out_src    out  SEL_W        index of requester whose beat is in data_out
// BEHAVIOUR
//  Registers: state{IDLE,BUSY}, owner, ptr (RR pointer), cnt, out_valid, out_src
//  Reset (rst_n=0 at posedge), all outputs: state=IDLE, owner=sel=0, ptr=0,
//   cnt=0, out_valid=0, out_src=0, busy=0; gnt=0 (IDLE implies gnt=0)
//  IDLE: if |req, owner <= first i with req[i]=1, scanning ptr, ptr+1, ...
//   modulo INPUT_COUNT; sel <= that i; cnt <= 0; -> BUSY. Else stay IDLE.
//   Arbitration costs one bubble cycle; gnt=0 in IDLE.
//  BUSY: beat = req[owner] & dn_ready; gnt[owner] = beat, other gnt bits 0.
//   On beat: cnt <= cnt+1.
//   On beat, end burst if last[owner] | (cnt+1 == BURST_MAX):
//    ptr <= (owner+1) mod INPUT_COUNT (wraps INPUT_COUNT-1 -> 0); -> IDLE.
//   If req[owner]=0 (any dn_ready): release with no beat; ptr <= owner+1 mod N;
//    -> IDLE.
//   If dn_ready=0 with req[owner]=1: stall; owner, sel, cnt hold; gnt=0.
//  out_valid <= beat; out_src <= owner every cycle (out_src don't-care when
//   out_valid=0). Both are visible in the same cycle the mux data_out shows
//   the beat (1-cycle latency gnt -> out_valid).
//  sel changes only on the IDLE->BUSY edge; it is stable for a whole burst.
//  Requesters other than owner are ignored while BUSY; their req is not
//   dropped by the scheduler.
//  last/req of non-owners and last[owner] without a beat have no effect.
//  Reset mid-burst: abort at that edge. Next cycle: out_valid=0, IDLE,
//   ptr=0. Matches the mux clearing data_out.
//  No starvation: every requester holding req is served within
//   (INPUT_COUNT-1) bursts.
// TESTING
//  T1 reset: rst_n=0 for 2 clk with req=8'hFF -> gnt=0, sel=0, busy=0, out_valid=0
//  T2 single: req[2]=1, dn_ready=1, last[2] on 3rd beat -> 1 IDLE cycle, sel=2,
//     gnt[2] for 3 cycles, out_valid 3 cycles delayed 1 with out_src=2, then
//     IDLE, ptr=3
//  T3 rotation: req=8'b1000_0001 held, last=0, BURST_MAX=4 -> 4 beats from 0,
//     bubble, 4 beats from 7, bubble, 4 beats from 0; out_src tracks sel
//  T4 back-pressure: dn_ready=0 for 2 cycles after beat 2 of 4 -> gnt=0, cnt=2
//     holds, sel stable, out_valid=0 for 2 cycles, burst still totals 4 beats
//  T5 wrap: ptr=7, req[7]=req[1]=1 -> 7 served first, ptr wraps to 0, then 1
//     served; req[owner] drop mid-burst -> release, no beat, owner+1 next
//  T6 reset mid-burst: rst_n=0 during beat 2 of owner 5 -> next cycle
//     out_valid=0, busy=0, ptr=0; after release req[5] re-arbitrates from 0

Source files
------------

// File: rtl/mux_rr_scheduler.sv
// ----------------------------------------------------------------------------
// mux_rr_scheduler
//   Round-robin burst scheduler for a shared, registered N-to-1 mux.
//   Picks an owner among the requesters, drives the mux select for the whole
//   burst and issues a per-beat grant to the owner while downstream is ready.
//   out_valid/out_src line up with the mux's registered data_out (one cycle
//   after the grant).
//
// Ports
//   clk        in   clock, all state updates on posedge
//   rst_n      in   synchronous active-low reset
//   req        in   [INPUT_COUNT] requester i has a beat on its slice
//   last       in   [INPUT_COUNT] current beat of requester i ends its burst
//   dn_ready   in   downstream accepts a beat this cycle
//   gnt        out  [INPUT_COUNT] one-hot beat accept (combinational)
//   sel        out  [SEL_W] mux select, equals registered owner
//   busy       out  high while a burst owner is selected
//   out_valid  out  mux data_out holds a valid beat this cycle
//   out_src    out  [SEL_W] requester whose beat is in data_out
// ----------------------------------------------------------------------------
module mux_rr_scheduler #(
  parameter  int INPUT_COUNT = 8,
  parameter  int BURST_MAX   = 4,
  localparam int SEL_W       = $clog2(INPUT_COUNT),
  localparam int CNT_W       = $clog2(BURST_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INPUT_COUNT-1:0] req,
  input  logic [INPUT_COUNT-1:0] last,
  input  logic                   dn_ready,
  output logic [INPUT_COUNT-1:0] gnt,
  output logic [SEL_W-1:0]       sel,
  output logic                   busy,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       out_src
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q;
  logic [SEL_W-1:0] out_src_q;

  logic             beat_s;
  logic             end_burst_s;
  logic             pick_found_s;
  logic [SEL_W-1:0] pick_idx_s;
  logic [SEL_W:0]   cand_s;
  logic [SEL_W-1:0] owner_inc_s;

  // Round-robin pick: scan offsets from the top down so the smallest offset
  // from ptr that has a request is the one left standing.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int k = INPUT_COUNT - 1; k >= 0; k--) begin
      cand_s = {1'b0, ptr_q} + (SEL_W + 1)'(k);
      if (cand_s >= (SEL_W + 1)'(INPUT_COUNT)) begin
        cand_s = cand_s - (SEL_W + 1)'(INPUT_COUNT);
      end else begin
        cand_s = cand_s;
      end
      if (req[cand_s[SEL_W-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s[SEL_W-1:0];
      end else begin
        pick_found_s = pick_found_s;
        pick_idx_s   = pick_idx_s;
      end
    end
  end

  // Beat qualification and end-of-burst detection for the current owner.
  always_comb begin
    beat_s      = (state_q == BUSY) & req[owner_q] & dn_ready;
    end_burst_s = last[owner_q] | ((cnt_q + CNT_W'(1)) == CNT_W'(BURST_MAX));
    if (owner_q == SEL_W'(INPUT_COUNT - 1)) begin
      owner_inc_s = '0;
    end else begin
      owner_inc_s = owner_q + SEL_W'(1);
    end
  end

  // One-hot grant to the owner on an accepted beat.
  always_comb begin
    gnt = '0;
    if (beat_s) begin
      gnt[owner_q] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  // Next-state logic: arbitration bubble in IDLE, beat/stall/release in BUSY.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          owner_d = pick_idx_s;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (beat_s) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (end_burst_s) begin
            ptr_d   = owner_inc_s;
            state_d = IDLE;
          end else begin
            state_d = BUSY;
          end
        end else if (!req[owner_q]) begin
          // Owner withdrew: release without a beat and move past it.
          ptr_d   = owner_inc_s;
          state_d = IDLE;
        end else begin
          // Back-pressure stall: everything holds.
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= beat_s;
      out_src_q   <= owner_q;
    end
  end

  assign sel       = owner_q;
  assign busy      = (state_q == BUSY);
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_mux_rr_scheduler
//   Directed scenarios followed by a randomized phase; every cycle the DUT is
//   compared against a behavioural model of the scheduling rules.
// ----------------------------------------------------------------------------
module tb_mux_rr_scheduler;

  localparam int N  = 8;
  localparam int BM = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] last;
  logic         dn_ready;
  logic [N-1:0] gnt;
  logic [2:0]   sel;
  logic         busy;
  logic         out_valid;
  logic [2:0]   out_src;

  int errors;
  int checks;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_ov;
  int m_src;

  mux_rr_scheduler #(.INPUT_COUNT(N), .BURST_MAX(BM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .dn_ready  (dn_ready),
    .gnt       (gnt),
    .sel       (sel),
    .busy      (busy),
    .out_valid (out_valid),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_ov    = 1'b0;
    m_src   = 0;
  endtask

  // Apply the scheduling rules for one clock edge.
  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l,
                            input logic d, input logic rn);
    bit beat;
    bit found;
    int c;
    if (!rn) begin
      model_reset();
    end else begin
      beat  = m_busy && r[m_owner] && d;
      m_ov  = beat;
      m_src = m_owner;
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && r[c]) begin
            found   = 1'b1;
            m_owner = c;
          end
        end
        if (found) begin
          m_cnt  = 0;
          m_busy = 1'b1;
        end
      end else if (beat) begin
        m_cnt = m_cnt + 1;
        if (l[m_owner] || m_cnt == BM) begin
          m_ptr  = (m_owner + 1) % N;
          m_busy = 1'b0;
        end
      end else if (!r[m_owner]) begin
        m_ptr  = (m_owner + 1) % N;
        m_busy = 1'b0;
      end
    end
  endtask

  // One cycle: drive after negedge, check grant, clock, check registered outputs.
  task automatic tick(input logic [N-1:0] r, input logic [N-1:0] l,
                      input logic d, input logic rn, input string tag);
    logic [N-1:0] e_gnt;
    req      = r;
    last     = l;
    dn_ready = d;
    rst_n    = rn;
    #1;
    e_gnt = '0;
    if (m_busy && r[m_owner] && d) e_gnt[m_owner] = 1'b1;
    chk({tag, ".gnt"}, {24'd0, gnt}, {24'd0, e_gnt});
    @(posedge clk);
    model_step(r, l, d, rn);
    @(negedge clk);
    chk({tag, ".busy"},  {31'd0, busy},      {31'd0, m_busy});
    chk({tag, ".sel"},   {29'd0, sel},       32'(m_owner));
    chk({tag, ".ovld"},  {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) chk({tag, ".osrc"}, {29'd0, out_src}, 32'(m_src));
    if (!rn) chk({tag, ".rst_src"}, {29'd0, out_src}, 32'd0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    req      = '0;
    last     = '0;
    dn_ready = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // T1: reset held with all requests asserted
    tick(8'hFF, 8'h00, 1'b1, 1'b0, "t1");
    tick(8'hFF, 8'h00, 1'b1, 1'b0, "t1");

    // T2: single requester 2, last on third beat
    tick(8'h04, 8'h00, 1'b1, 1'b1, "t2");
    tick(8'h04, 8'h00, 1'b1, 1'b1, "t2");
    tick(8'h04, 8'h00, 1'b1, 1'b1, "t2");
    tick(8'h04, 8'h04, 1'b1, 1'b1, "t2");
    tick(8'h00, 8'h00, 1'b1, 1'b1, "t2");
    // ptr is now 3: requests 1 and 4 -> 4 wins
    tick(8'h12, 8'h12, 1'b1, 1'b1, "t2p");
    chk("t2.ptr3", {29'd0, sel}, 32'd4);
    tick(8'h12, 8'h12, 1'b1, 1'b1, "t2p");
    tick(8'h00, 8'h00, 1'b1, 1'b1, "t2p");

    // T3: rotation between 0 and 7 with forced BURST_MAX rotation
    tick(8'h00, 8'h00, 1'b1, 1'b0, "t3r");
    for (int i = 0; i < 15; i++) tick(8'h81, 8'h00, 1'b1, 1'b1, "t3");
    tick(8'h00, 8'h00, 1'b1, 1'b1, "t3");
    tick(8'h00, 8'h00, 1'b1, 1'b1, "t3");

    // T4: back-pressure after beat 2
    tick(8'h00, 8'h00, 1'b1, 1'b0, "t4r");
    tick(8'h08, 8'h00, 1'b1, 1'b1, "t4");
    tick(8'h08, 8'h00, 1'b1, 1'b1, "t4");
    tick(8'h08, 8'h00, 1'b1, 1'b1, "t4");
    tick(8'h08, 8'h08, 1'b0, 1'b1, "t4s");
    tick(8'h08, 8'h08, 1'b0, 1'b1, "t4s");
    chk("t4.sel_stable", {29'd0, sel}, 32'd3);
    tick(8'h08, 8'h00, 1'b1, 1'b1, "t4");
    tick(8'h08, 8'h00, 1'b1, 1'b1, "t4");
    chk("t4.done", {31'd0, busy}, 32'd0);
    tick(8'h00, 8'h00, 1'b1, 1'b1, "t4");

    // T5: get ptr to 7, then wrap 7 -> 1, then owner drops request
    tick(8'h00, 8'h00, 1'b1, 1'b0, "t5r");
    tick(8'h40, 8'h40, 1'b1, 1'b1, "t5a");
    tick(8'h40, 8'h40, 1'b1, 1'b1, "t5a");
    tick(8'h82, 8'h00, 1'b1, 1'b1, "t5");
    chk("t5.first7", {29'd0, sel}, 32'd7);
    for (int i = 0; i < 5; i++) tick(8'h82, 8'h00, 1'b1, 1'b1, "t5");
    chk("t5.then1", {29'd0, sel}, 32'd1);
    tick(8'h82, 8'h00, 1'b1, 1'b1, "t5");
    tick(8'h80, 8'h00, 1'b1, 1'b1, "t5d");
    tick(8'h80, 8'h00, 1'b1, 1'b1, "t5d");
    tick(8'h00, 8'h00, 1'b1, 1'b1, "t5d");

    // T6: reset during beat 2 of owner 5
    tick(8'h00, 8'h00, 1'b1, 1'b0, "t6r");
    tick(8'h20, 8'h00, 1'b1, 1'b1, "t6");
    tick(8'h20, 8'h00, 1'b1, 1'b1, "t6");
    tick(8'h20, 8'h00, 1'b1, 1'b0, "t6x");
    tick(8'h21, 8'h00, 1'b1, 1'b1, "t6");
    chk("t6.from0", {29'd0, sel}, 32'd0);
    tick(8'h21, 8'h01, 1'b1, 1'b1, "t6");
    tick(8'h00, 8'h00, 1'b1, 1'b1, "t6");

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      tick(N'($urandom), N'($urandom & $urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 99) >= 2), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
